// File: rtl/actel_s2_bank.sv
// actel_s2_bank: WIDTH independent Actel C2 logic lanes, each with an output
// flip-flop (S-module). A per-lane mode bit picks the registered or the
// combinational value. Mode bits arrive through a serial config port and
// are committed to all lanes at once.
module actel_s2_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d00,
   input  logic [WIDTH-1:0] d01,
   input  logic [WIDTH-1:0] d10,
   input  logic [WIDTH-1:0] d11,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             en,
   input  logic             cfg_start,
   input  logic             cfg_bit,
   input  logic             cfg_abort,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic [WIDTH-1:0] mode,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] out
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] sel1;
   logic [WIDTH-1:0] sel0;
   logic [WIDTH-1:0] comb;
   logic             last_bit;

   assign sel1     = a1 | b1;
   assign sel0     = a0 & b0;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // C2 four-way mux, evaluated bitwise so every lane is independent
   always_comb begin
      comb = (~sel1 & ~sel0 & d00) |
             (~sel1 &  sel0 & d01) |
             ( sel1 & ~sel0 & d10) |
             ( sel1 &  sel0 & d11);
   end

   // Lane flip-flops capture the C2 value on enabled edges, whatever the mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= comb;
      end
   end

   // Registered lanes present q; q already holds the last capture when mode sets
   always_comb begin
      out = (mode & q) | (~mode & comb);
   end

   // Config FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Config FSM next state: abort beats the final bit, start beats abort in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_start) state_nxt = SHIFT;
         SHIFT:   if (cfg_abort) state_nxt = IDLE;
                  else if (last_bit) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Config FSM outputs, decoded from the state alone
   always_comb begin
      cfg_busy = (state != IDLE);
      cfg_done = (state == COMMIT);
   end

   // Bit counter, shadow shift-in and atomic mode commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         shadow <= '0;
         mode   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_start) cnt <= '0;
            end
            SHIFT: begin
               if (cfg_abort) begin
                  shadow <= '0;
               end else begin
                  shadow[cnt] <= cfg_bit;
                  cnt         <= cnt + CNT_W'(1);
               end
            end
            COMMIT: begin
               mode <= shadow;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_actel_s2_bank.sv
// Testbench for actel_s2_bank with WIDTH=4: reference model plus a queue of
// expected lane outputs pushed at drive time and popped at sample time.
module tb_actel_s2_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] d00, d01, d10, d11, a1, b1, a0, b0;
   logic       en, cfg_start, cfg_bit, cfg_abort;
   logic       cfg_busy, cfg_done;
   logic [3:0] mode, q, out;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] m_q    = '0;
   logic [3:0] m_mode = '0;
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   actel_s2_bank #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .d00(d00), .d01(d01), .d10(d10), .d11(d11),
      .a1(a1), .b1(b1), .a0(a0), .b0(b0),
      .en(en), .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_abort(cfg_abort),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done),
      .mode(mode), .q(q), .out(out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // C2 truth table, one lane at a time
   function automatic logic [3:0] m_comb();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
         case ({a1[i] | b1[i], a0[i] & b0[i]})
            2'b00:   r[i] = d00[i];
            2'b01:   r[i] = d01[i];
            2'b10:   r[i] = d10[i];
            default: r[i] = d11[i];
         endcase
      end
      return r;
   endfunction

   function automatic logic [3:0] m_out();
      logic [3:0] c;
      logic [3:0] r;
      c = m_comb();
      for (int i = 0; i < 4; i++) r[i] = m_mode[i] ? m_q[i] : c[i];
      return r;
   endfunction

   // advance one edge, update the model's flip-flops, land 1 time unit after
   task automatic cyc();
      @(posedge clk);
      if (rst) m_q = '0;
      else if (en) m_q = m_comb();
      #1;
   endtask

   task automatic apply(input logic [31:0] s, input string tag);
      {a1, b1, a0, b0, d00, d01, d10, d11} = s;
      sb.push_back(m_out());
      #1;
      chk(tag, out, sb.pop_front());
   endtask

   task automatic load(input logic [3:0] bits, input string tag);
      cfg_start = 1'b1;
      cyc();
      chk({tag, "_busy_start"}, cfg_busy, 1);
      for (int k = 0; k < 4; k++) begin
         cfg_bit   = bits[k];
         cfg_start = (k < 3);   // held high while busy: must be ignored
         cyc();
         if (k < 3) chk({tag, "_done_shift"}, cfg_done, 0);
      end
      cfg_start = 1'b0;
      chk({tag, "_done_commit"}, cfg_done, 1);
      chk({tag, "_busy_commit"}, cfg_busy, 1);
      chk({tag, "_mode_before"}, mode, m_mode);
      cyc();
      m_mode = bits;
      chk({tag, "_mode_after"}, mode, bits);
      chk({tag, "_done_after"}, cfg_done, 0);
      chk({tag, "_busy_after"}, cfg_busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] s;
      logic [3:0]  hold;
      rst = 1'b1; en = 1'b0; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
      {a1, b1, a0, b0, d00, d01, d10, d11} = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         apply($urandom(), "warm");
      end

      // reset asserted mid-cycle
      cyc();
      #2;
      rst = 1'b1; m_q = '0; m_mode = '0;
      #1;
      chk("rst_q", q, 4'h0);
      chk("rst_mode", mode, 4'h0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_done", cfg_done, 0);
      a0 = 4'hF; b0 = 4'hF; a1 = 4'h0; b1 = 4'h0;
      d00 = 4'h5; d01 = 4'hA; d10 = 4'h3; d11 = 4'hC;
      #1;
      chk("rst_out_d01", out, 4'hA);
      cyc();
      rst = 1'b0;

      // combinational sweep of lane 0, other lanes random
      en = 1'b0;
      for (int i = 0; i < 256; i++) begin
         cyc();
         s = $urandom();
         s[28] = i[7]; s[24] = i[6]; s[20] = i[5]; s[16] = i[4];
         s[12] = i[3]; s[8]  = i[2]; s[4]  = i[1]; s[0]  = i[0];
         apply(s, "comb_sweep");
      end

      // abort on the 4th bit; mode stays 0000
      en = 1'b1;
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cfg_bit = 1'b1;
         cyc();
      end
      cfg_abort = 1'b1;
      cyc();
      cfg_abort = 1'b0;
      chk("abort_busy", cfg_busy, 0);
      chk("abort_done", cfg_done, 0);
      chk("abort_mode", mode, 4'h0);
      cyc();
      chk("abort_done2", cfg_done, 0);
      chk("abort_mode2", mode, 4'h0);
      // start and abort together in IDLE: start wins
      cfg_start = 1'b1; cfg_abort = 1'b1;
      cyc();
      chk("start_wins_busy", cfg_busy, 1);
      cfg_start = 1'b0;
      cyc();
      cfg_abort = 1'b0;
      chk("abort_first_busy", cfg_busy, 0);
      chk("abort_first_mode", mode, 4'h0);

      // reset during the cycle-3 SHIFT loses the load
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0; cfg_bit = 1'b1;
      cyc();
      cyc();
      #2;
      rst = 1'b1; m_q = '0;
      #1;
      chk("rstload_busy", cfg_busy, 0);
      chk("rstload_mode", mode, 4'h0);
      chk("rstload_q", q, 4'h0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("rstload_idle", cfg_busy, 0);
      load(4'b0101, "ld0101");
      for (int k = 0; k < 4; k++) begin
         cyc();
         apply($urandom(), "out0101");
      end

      // mode 1101: lanes 0,2,3 one cycle late, lane 1 same cycle
      load(4'b1101, "ld1101");
      for (int k = 0; k < 6; k++) begin
         cyc();
         apply($urandom(), "out1101");
      end

      // enable hold with all lanes registered
      load(4'b1111, "ld1111");
      cyc();
      apply($urandom(), "pre_hold");
      en = 1'b0;
      cyc();
      hold = m_q;
      for (int k = 0; k < 3; k++) begin
         apply($urandom(), "hold_out");
         chk("hold_q", q, hold);
         cyc();
      end
      en = 1'b1;
      cyc();
      chk("capture_q", q, m_q);
      apply($urandom(), "capture_out");

      // reset clears a non-zero mode
      cyc();
      #2;
      rst = 1'b1; m_q = '0; m_mode = '0;
      #1;
      chk("rst2_mode", mode, 4'h0);
      chk("rst2_q", q, 4'h0);
      chk("rst2_busy", cfg_busy, 0);
      apply($urandom(), "rst2_out");
      cyc();
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
